ppt_regbank: RTL and testbench
==============================

Name: ppt_regbank

Overview:
- Parametrised multi-channel register bank between the I2C slave byte interface and NUM_CH PPT pulse controllers.
- Byte-wide, 8-bit address space; one 16-byte window per channel plus a global window at 0xF0.
- Added over the single-channel map:
  - staged/active config double-buffering;
  - START/ABORT strobes;
  - atomic 16-bit COUNT_DONE reads;
  - sticky W1C DONE;
  - optional interrupt.

Parameters:
NUM_CH, 2, number of PPT channels (1..8).
CNT_W, 16, width of period/width/count/count_done (9..16; upper byte masked to CNT_W-8 bits).
DIV_W, 5, clk_div width (1..8).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
address  in  8  byte address; [7:4] window (0..NUM_CH-1 = channel, 0xF = global), [3:0] offset
data_in  in  8  write data
write_enable  in  1  one-cycle write strobe
read_enable  in  1  one-cycle read strobe (issued when data_out is sampled)
data_out  out  8  read data, combinational from address
clk_div  out  NUM_CH*DIV_W  active clock divider, channel c at [c*DIV_W +: DIV_W]
period, width, count  out  NUM_CH*CNT_W each  active config, same packing
run_ppt  out  NUM_CH  per-channel run enable
start_ppt  out  NUM_CH  one-cycle start pulse
abort_ppt  out  NUM_CH  one-cycle abort pulse
count_done  in  NUM_CH*CNT_W  live fire counts
done  in  NUM_CH  per-channel done level
irq  out  1  level interrupt, active-high

Behaviour:
- Channel offsets:
  - 0 CLK_DIV (rst 9), 1/2 PERIOD_L/H (128/0), 3/4 WIDTH_L/H (1/0), 5/6 COUNT_L/H (16/0).
  - 7 CTRL: bit0 RUN rw (rst 0); bit1 START and bit2 ABORT are write-1 strobes that read 0.
  - 8 CDONE_L, 9 CDONE_H, A STATUS. Offsets B..F read 0 and ignore writes.
- Global window:
  - 0xF0 ID, ro, reads {4'h1, NUM_CH[3:0]}.
  - 0xF1 IRQ_STAT, W1C, bit c mirrors channel c DONE_STICKY.
  - 0xF2 IRQ_EN rw (rst 0).
- Unmapped windows (c ≥ NUM_CH, not 0xF) read 0 and ignore writes.
- Staging vs active:
  - Offsets 0-6 write staging registers (1-cycle latency).
  - Active outputs load from staging every cycle while run_ppt[c]=0.
  - While run_ppt[c]=1, active outputs load only in the cycle start_ppt[c] pulses.
  - A write to staging and a commit in the same cycle: active takes the pre-write staging value.
- Strobes:
  - Write to CTRL with bit1=1 produces start_ppt[c]=1 the next cycle, only if RUN (new value) is 1.
  - bit2 produces abort_ppt[c] the next cycle and forces RUN to 0.
  - ABORT wins over START.
- Atomic read:
  - read_enable at offset 8 latches count_done[c][CNT_W-1:8] into snap_h[c].
  - Offset 9 returns snap_h[c], not the live value.
  - Offset 8 returns live low byte.
- STATUS:
  - bit0 DONE = live done[c].
  - bit1 DONE_STICKY set on rising edge of done[c] (registered done_q); cleared by writing 1 to STATUS bit1 or IRQ_STAT bit c.
  - Set wins over clear in the same cycle.
  - Rising edge of RUN clears DONE_STICKY.
- irq = |(sticky & irq_en), registered, 1 cycle after sticky sets.
- Reset: all outputs 0 except active/staging config at defaults; snap_h=0; done_q=0.
- Reset while running drops run_ppt the cycle after rst; no strobes emitted.

Optional Feature:
PPT_REGBANK_IRQ_EN
- Defined: IRQ_EN register, IRQ_STAT W1C alias, and registered irq output exist as above.
- Undefined: irq tied 0; 0xF1/0xF2 read 0 and ignore writes; sticky still clearable via STATUS.

Decomposition:
- Package ppt_regbank_pkg holds:
  - offset constants (OFS_CLK_DIV..OFS_STATUS), GLOBAL_WIN=4'hF, CTRL bit indices;
  - reset-default constants (DEF_CLK_DIV=9, DEF_PERIOD=128, DEF_WIDTH=1, DEF_COUNT=16), ID_VERSION=4'h1.
- Sub-module ppt_regbank_ch: one channel's staging/active/CTRL/snapshot/sticky logic; instantiated NUM_CH times via generate. The top handles decode, read mux, global regs, irq.

Test Plan:
- Reset, read channel 0 offsets 0-7 and 0xF0 -> 09,80,00,01,00,10,00,00 and 0x12 (NUM_CH=2); clk_div[4:0]=9, period[15:0]=128.
- RUN=0, write ch1 PERIOD_L=0x40 -> period[31:16]=0x0040 one cycle after the write.
- Run active:
  - RUN=1 on ch0, then write PERIOD_L=0x20 -> period[15:0] stays 128.
  - Write CTRL=0x03 -> start_ppt[0] pulses one cycle, period[15:0]=0x0020.
- count_done[15:0]=0x12FF; read offset 8 (0xFF); change input to 0x1300; read offset 9 -> 0x12, not 0x13.
- Sticky/irq:
  - done[1] 0->1 with IRQ_EN=0x02 -> STATUS ch1=0x03, irq=1.
  - Write 0xF1=0x02 -> sticky 0, irq=0 next cycle.
  - Repeat with rising edge coincident with clear -> sticky stays 1.
- CTRL=0x07 on ch0 -> abort_ppt[0] pulse, start_ppt[0]=0, RUN reads 0; assert rst mid-run -> run_ppt=0, config at defaults.

Source files
------------

// File: rtl/ppt_regbank_pkg.sv
// ppt_regbank_pkg: register map offsets, control bit indices and reset defaults for ppt_regbank.
package ppt_regbank_pkg;
    localparam logic [3:0] OFS_CLK_DIV  = 4'h0;
    localparam logic [3:0] OFS_PERIOD_L = 4'h1;
    localparam logic [3:0] OFS_PERIOD_H = 4'h2;
    localparam logic [3:0] OFS_WIDTH_L  = 4'h3;
    localparam logic [3:0] OFS_WIDTH_H  = 4'h4;
    localparam logic [3:0] OFS_COUNT_L  = 4'h5;
    localparam logic [3:0] OFS_COUNT_H  = 4'h6;
    localparam logic [3:0] OFS_CTRL     = 4'h7;
    localparam logic [3:0] OFS_CDONE_L  = 4'h8;
    localparam logic [3:0] OFS_CDONE_H  = 4'h9;
    localparam logic [3:0] OFS_STATUS   = 4'hA;
    localparam logic [3:0] GLOBAL_WIN    = 4'hF;
    localparam logic [3:0] GOFS_ID       = 4'h0;
    localparam logic [3:0] GOFS_IRQ_STAT = 4'h1;
    localparam logic [3:0] GOFS_IRQ_EN   = 4'h2;
    localparam int CTRL_RUN      = 0;
    localparam int CTRL_START    = 1;
    localparam int CTRL_ABORT    = 2;
    localparam int STATUS_DONE   = 0;
    localparam int STATUS_STICKY = 1;
    localparam int DEF_CLK_DIV = 9;
    localparam int DEF_PERIOD  = 128;
    localparam int DEF_WIDTH   = 1;
    localparam int DEF_COUNT   = 16;
    localparam logic [3:0] ID_VERSION = 4'h1;
endpackage

// File: rtl/ppt_regbank_ch.sv
// ppt_regbank_ch: one channel's staging/active config, CTRL strobes, COUNT_DONE snapshot and sticky DONE.
module ppt_regbank_ch
    import ppt_regbank_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DIV_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [3:0]       ofs,
    input  logic [7:0]       wdata,
    input  logic [CNT_W-1:0] count_done,
    input  logic             done,
    input  logic             sticky_clr,
    output logic [DIV_W-1:0] clk_div,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] count,
    output logic             run,
    output logic             start,
    output logic             abort,
    output logic             sticky,
    output logic [7:0]       rdata
);
    logic [DIV_W-1:0] s_div;
    logic [CNT_W-1:0] s_per, s_wid, s_cnt;
    logic [CNT_W-9:0] snap_h;
    logic             done_q, ctrl_we, run_set, clr;
    assign ctrl_we = we && ofs == OFS_CTRL;
    assign run_set = ctrl_we && wdata[CTRL_RUN] && !wdata[CTRL_ABORT] && !run;
    assign clr = (we && ofs == OFS_STATUS && wdata[STATUS_STICKY]) || sticky_clr || run_set;
    always_ff @(posedge clk) begin
        if (rst) begin
            s_div   <= DIV_W'(DEF_CLK_DIV);
            s_per   <= CNT_W'(DEF_PERIOD);
            s_wid   <= CNT_W'(DEF_WIDTH);
            s_cnt   <= CNT_W'(DEF_COUNT);
            clk_div <= DIV_W'(DEF_CLK_DIV);
            period  <= CNT_W'(DEF_PERIOD);
            width   <= CNT_W'(DEF_WIDTH);
            count   <= CNT_W'(DEF_COUNT);
            run     <= 1'b0;
            start   <= 1'b0;
            abort   <= 1'b0;
            snap_h  <= '0;
            done_q  <= 1'b0;
            sticky  <= 1'b0;
        end else begin
            if (we && ofs == OFS_CLK_DIV)  s_div <= wdata[DIV_W-1:0];
            if (we && ofs == OFS_PERIOD_L) s_per[7:0] <= wdata;
            if (we && ofs == OFS_PERIOD_H) s_per[CNT_W-1:8] <= wdata[CNT_W-9:0];
            if (we && ofs == OFS_WIDTH_L)  s_wid[7:0] <= wdata;
            if (we && ofs == OFS_WIDTH_H)  s_wid[CNT_W-1:8] <= wdata[CNT_W-9:0];
            if (we && ofs == OFS_COUNT_L)  s_cnt[7:0] <= wdata;
            if (we && ofs == OFS_COUNT_H)  s_cnt[CNT_W-1:8] <= wdata[CNT_W-9:0];
            // Active config sees the staging value from before any same-cycle write
            if (!run || start) begin
                clk_div <= s_div;
                period  <= s_per;
                width   <= s_wid;
                count   <= s_cnt;
            end
            start <= ctrl_we && wdata[CTRL_START] && wdata[CTRL_RUN] && !wdata[CTRL_ABORT];
            abort <= ctrl_we && wdata[CTRL_ABORT];
            if (ctrl_we) run <= wdata[CTRL_RUN] && !wdata[CTRL_ABORT];
            if (re && ofs == OFS_CDONE_L) snap_h <= count_done[CNT_W-1:8];
            done_q <= done;
            sticky <= (done && !done_q) || (sticky && !clr);
        end
    end
    always_comb begin
        rdata = 8'h00;
        case (ofs)
            OFS_CLK_DIV:  rdata = 8'(s_div);
            OFS_PERIOD_L: rdata = s_per[7:0];
            OFS_PERIOD_H: rdata = 8'(s_per[CNT_W-1:8]);
            OFS_WIDTH_L:  rdata = s_wid[7:0];
            OFS_WIDTH_H:  rdata = 8'(s_wid[CNT_W-1:8]);
            OFS_COUNT_L:  rdata = s_cnt[7:0];
            OFS_COUNT_H:  rdata = 8'(s_cnt[CNT_W-1:8]);
            OFS_CTRL:     rdata = 8'(run);
            OFS_CDONE_L:  rdata = count_done[7:0];
            OFS_CDONE_H:  rdata = 8'(snap_h);
            OFS_STATUS:   rdata = {6'b0, sticky, done};
            default:      rdata = 8'h00;
        endcase
    end
endmodule

// File: rtl/ppt_regbank.sv
// ppt_regbank: multi-channel PPT register bank with address decode, read mux and global window.
// PPT_REGBANK_IRQ_EN enables IRQ_EN, the IRQ_STAT W1C alias and the irq output.
module ppt_regbank
    import ppt_regbank_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    parameter int DIV_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              address,
    input  logic [7:0]              data_in,
    input  logic                    write_enable,
    input  logic                    read_enable,
    output logic [7:0]              data_out,
    output logic [NUM_CH*DIV_W-1:0] clk_div,
    output logic [NUM_CH*CNT_W-1:0] period,
    output logic [NUM_CH*CNT_W-1:0] width,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       run_ppt,
    output logic [NUM_CH-1:0]       start_ppt,
    output logic [NUM_CH-1:0]       abort_ppt,
    input  logic [NUM_CH*CNT_W-1:0] count_done,
    input  logic [NUM_CH-1:0]       done,
    output logic                    irq
);
    logic [3:0]        win, ofs;
    logic [7:0]        id, g_rdata;
    logic [7:0]        ch_rdata [NUM_CH];
    logic [NUM_CH-1:0] ch_we, sticky, sticky_clr;
    assign win = address[7:4];
    assign ofs = address[3:0];
    assign id  = {ID_VERSION, 4'(NUM_CH)};
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_we[c] = write_enable && win == 4'(c);
        ppt_regbank_ch #(.CNT_W(CNT_W), .DIV_W(DIV_W)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .we         (ch_we[c]),
            .re         (read_enable && win == 4'(c)),
            .ofs        (ofs),
            .wdata      (data_in),
            .count_done (count_done[c*CNT_W +: CNT_W]),
            .done       (done[c]),
            .sticky_clr (sticky_clr[c]),
            .clk_div    (clk_div[c*DIV_W +: DIV_W]),
            .period     (period[c*CNT_W +: CNT_W]),
            .width      (width[c*CNT_W +: CNT_W]),
            .count      (count[c*CNT_W +: CNT_W]),
            .run        (run_ppt[c]),
            .start      (start_ppt[c]),
            .abort      (abort_ppt[c]),
            .sticky     (sticky[c]),
            .rdata      (ch_rdata[c])
        );
    end
`ifdef PPT_REGBANK_IRQ_EN
    logic [NUM_CH-1:0] irq_en;
    assign sticky_clr = (write_enable && win == GLOBAL_WIN && ofs == GOFS_IRQ_STAT) ? data_in[NUM_CH-1:0] : '0;
    assign g_rdata = ofs == GOFS_ID ? id : ofs == GOFS_IRQ_STAT ? 8'(sticky) : ofs == GOFS_IRQ_EN ? 8'(irq_en) : 8'h00;
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            if (write_enable && win == GLOBAL_WIN && ofs == GOFS_IRQ_EN) irq_en <= data_in[NUM_CH-1:0];
            irq <= |(sticky & irq_en);
        end
    end
`else
    logic unused_sticky;
    assign unused_sticky = |sticky;
    assign sticky_clr = '0;
    assign g_rdata = ofs == GOFS_ID ? id : 8'h00;
    assign irq = 1'b0;
`endif
    always_comb begin
        data_out = win == GLOBAL_WIN ? g_rdata : 8'h00;
        for (int i = 0; i < NUM_CH; i++) data_out = win == 4'(i) ? ch_rdata[i] : data_out;
    end
endmodule

// File: tb/tb_ppt_regbank.sv
// tb_ppt_regbank: directed self-checking bench for ppt_regbank (NUM_CH=2, CNT_W=16, DIV_W=5).
module tb_ppt_regbank;
`ifdef PPT_REGBANK_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    localparam logic [7:0] CLR_A = IRQ_ON ? 8'hF1 : 8'h1A;
    logic        clk = 0, rst = 1;
    logic [7:0]  address = 0, data_in = 0, data_out;
    logic        write_enable = 0, read_enable = 0, irq;
    logic [9:0]  clk_div;
    logic [31:0] period, width, count, count_done = 0;
    logic [1:0]  run_ppt, start_ppt, abort_ppt, done = 0;
    int n_cmp = 0, n_err = 0;
    logic [7:0] ch0_rst [8] = '{8'h09, 8'h80, 8'h00, 8'h01, 8'h00, 8'h10, 8'h00, 8'h00};

    ppt_regbank #(.NUM_CH(2), .CNT_W(16), .DIV_W(5)) dut (
        .clk(clk), .rst(rst), .address(address), .data_in(data_in),
        .write_enable(write_enable), .read_enable(read_enable), .data_out(data_out),
        .clk_div(clk_div), .period(period), .width(width), .count(count),
        .run_ppt(run_ppt), .start_ppt(start_ppt), .abort_ppt(abort_ppt),
        .count_done(count_done), .done(done), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a; data_in = d; write_enable = 1;
        @(negedge clk);
        write_enable = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        address = a; read_enable = 1;
        #1 check(tag, 32'(data_out), 32'(exp));
        @(negedge clk);
        read_enable = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        check("rst_run", 32'(run_ppt), 0);
        check("rst_strobes", 32'({start_ppt, abort_ppt}), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_clk_div", 32'(clk_div[4:0]), 9);
        check("rst_period", 32'(period[15:0]), 128);
        check("rst_width", 32'(width[15:0]), 1);
        check("rst_count", 32'(count[15:0]), 16);
        for (int i = 0; i < 8; i++) rd_chk($sformatf("rst_rd_%0d", i), 8'(i), ch0_rst[i]);
        rd_chk("id", 8'hF0, 8'h12);

        wr(8'h11, 8'h40);
        check("ch1_period_pre", 32'(period[31:16]), 32'h0080);
        @(negedge clk);
        check("ch1_period_post", 32'(period[31:16]), 32'h0040);

        wr(8'h07, 8'h01);
        check("run0_on", 32'(run_ppt[0]), 1);
        check("run0_no_start", 32'(start_ppt[0]), 0);
        wr(8'h01, 8'h20);
        @(negedge clk);
        check("run_hold_period", 32'(period[15:0]), 128);
        rd_chk("staged_period", 8'h01, 8'h20);
        wr(8'h07, 8'h03);
        check("start_pulse", 32'(start_ppt[0]), 1);
        check("start_period_pre", 32'(period[15:0]), 128);
        @(negedge clk);
        check("start_pulse_end", 32'(start_ppt[0]), 0);
        check("start_period_post", 32'(period[15:0]), 32'h0020);

        count_done[15:0] = 16'h12FF;
        rd_chk("cdone_l", 8'h08, 8'hFF);
        count_done[15:0] = 16'h1300;
        rd_chk("cdone_h_snap", 8'h09, 8'h12);
        rd_chk("cdone_l_live", 8'h08, 8'h00);

        wr(8'hF2, 8'h02);
        rd_chk("irq_en_rd", 8'hF2, IRQ_ON ? 8'h02 : 8'h00);
        done[1] = 1;
        @(negedge clk);
        check("irq_lat", 32'(irq), 0);
        @(negedge clk);
        check("irq_set", 32'(irq), 32'(IRQ_ON));
        rd_chk("status_sticky", 8'h1A, 8'h03);
        rd_chk("irq_stat_rd", 8'hF1, IRQ_ON ? 8'h02 : 8'h00);
        wr(CLR_A, 8'h02);
        @(negedge clk);
        check("irq_clr", 32'(irq), 0);
        rd_chk("status_cleared", 8'h1A, 8'h01);
        done[1] = 0;
        @(negedge clk);
        address = CLR_A; data_in = 8'h02; write_enable = 1; done[1] = 1;
        @(negedge clk);
        write_enable = 0;
        rd_chk("set_beats_clr", 8'h1A, 8'h03);
        wr(8'h1A, 8'h02);
        rd_chk("status_w1c", 8'h1A, 8'h01);

        wr(8'h07, 8'h07);
        check("abort_pulse", 32'(abort_ppt[0]), 1);
        check("abort_no_start", 32'(start_ppt[0]), 0);
        check("abort_run", 32'(run_ppt[0]), 0);
        rd_chk("abort_ctrl_rd", 8'h07, 8'h00);
        check("abort_pulse_end", 32'(abort_ppt[0]), 0);

        wr(8'h31, 8'h55);
        rd_chk("unmapped_win", 8'h31, 8'h00);
        wr(8'h0B, 8'h55);
        rd_chk("unmapped_ofs", 8'h0B, 8'h00);

        wr(8'h07, 8'h01);
        check("rerun", 32'(run_ppt[0]), 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rst2_run", 32'(run_ppt), 0);
        check("rst2_strobes", 32'({start_ppt, abort_ppt}), 0);
        check("rst2_period", 32'(period), 32'h0080_0080);
        check("rst2_clk_div", 32'(clk_div), 32'(10'b01001_01001));
        rd_chk("rst2_snap", 8'h09, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
